// File: rtl/strassen_pkg.sv
// strassen_pkg: shared types, product schedule and coefficient tables for strassen_seq_mm.
package strassen_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;
    typedef enum logic {MODE_FULL, MODE_VEC} mode_e;

    localparam int NPROD_FULL = 7;
    localparam int NPROD_VEC  = 4;

    localparam logic [2:0] FULL_FIRST = 3'd0;
    localparam logic [2:0] FULL_LAST  = 3'(NPROD_FULL - 1);
    localparam logic [2:0] VEC_FIRST  = 3'd1;
    localparam logic [2:0] VEC_LAST   = 3'(int'(VEC_FIRST) + NPROD_VEC - 1);

    localparam int E00 = 0;
    localparam int E01 = 1;
    localparam int E10 = 2;
    localparam int E11 = 3;

    localparam logic signed [1:0] CP = 2'sd1;
    localparam logic signed [1:0] CN = -2'sd1;
    localparam logic signed [1:0] CZ = 2'sd0;

    // Rows are M1..M7, columns are the C00, C01, C10, C11 targets
    localparam logic signed [1:0] COEF_FULL [7][4] = '{
        '{CP, CZ, CZ, CP},
        '{CZ, CZ, CP, CN},
        '{CZ, CP, CZ, CP},
        '{CP, CZ, CP, CZ},
        '{CN, CP, CZ, CZ},
        '{CZ, CZ, CZ, CP},
        '{CP, CZ, CZ, CZ}
    };

    localparam logic signed [1:0] COEF_VEC [7][4] = '{
        '{CZ, CZ, CZ, CZ},
        '{CZ, CZ, CP, CZ},
        '{CP, CZ, CZ, CZ},
        '{CZ, CZ, CP, CZ},
        '{CP, CZ, CZ, CZ},
        '{CZ, CZ, CZ, CZ},
        '{CZ, CZ, CZ, CZ}
    };

endpackage

// File: rtl/strassen_seq_mm_mul.sv
// smm_mul_pipe: signed (DW+1)x(DW+1) multiplier with LAT register stages; valid and tag ride along.
module smm_mul_pipe #(
    parameter int DW  = 32,
    parameter int LAT = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [2:0]            in_tag,
    input  logic signed [DW:0]    a,
    input  logic signed [DW:0]    b,
    output logic                  out_valid,
    output logic [2:0]            out_tag,
    output logic signed [2*DW+1:0] p,
    output logic                  busy
);

    logic [LAT-1:0]         v_q, v_d;
    logic [2:0]             tag_q [LAT];
    logic [2:0]             tag_d [LAT];
    logic signed [2*DW+1:0] p_q [LAT];
    logic signed [2*DW+1:0] p_d [LAT];

    always_comb begin
        v_d[0]   = in_valid;
        tag_d[0] = in_tag;
        p_d[0]   = a * b;
        for (int i = 1; i < LAT; i++) begin
            v_d[i]   = v_q[i-1];
            tag_d[i] = tag_q[i-1];
            p_d[i]   = p_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) v_q <= '0;
        else     v_q <= v_d;
    end

    always_ff @(posedge clk) begin
        tag_q <= tag_d;
        p_q   <= p_d;
    end

    assign out_valid = v_q[LAT-1];
    assign out_tag   = tag_q[LAT-1];
    assign p         = p_q[LAT-1];
    assign busy      = |v_q;

endmodule

// File: rtl/strassen_seq_mm.sv
// strassen_seq_mm: sequential 2x2 Strassen multiplier sharing one pipelined multiplier.
// Define STRASSEN_SAT_EN to clamp C elements and report sat; otherwise C wraps.
module strassen_seq_mm
    import strassen_pkg::*;
#(
    parameter int DATAWIDTH = 32,
    parameter int MULT_LAT  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   mode,
    input  logic [4*DATAWIDTH-1:0] A,
    input  logic [4*DATAWIDTH-1:0] B,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*DATAWIDTH-1:0] C,
    output logic                   sat,
    output logic                   busy
);

    localparam int DW = DATAWIDTH;
    localparam int PW = 2*DW + 2;
    localparam int AW = 2*DW + 4;

`ifdef STRASSEN_SAT_EN
    localparam logic signed [AW-1:0] SMAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW-1:0] SMIN = ~SMAX;
`endif

    state_e                state_q, state_d;
    mode_e                 mode_q, mode_d;
    logic [4*DW-1:0]       a_q, a_d, b_q, b_d, c_q, c_d;
    logic [2:0]            idx_q, idx_d;
    logic signed [AW-1:0]  acc_q [4];
    logic signed [AW-1:0]  acc_d [4];
    logic                  sat_q, sat_d;
    logic signed [DW:0]    ae [4];
    logic signed [DW:0]    be [4];
    logic signed [DW:0]    t_op, s_op;
    logic                  issue, mul_valid, mul_busy;
    logic [2:0]            mul_tag;
    logic signed [PW-1:0]  mul_p;
    logic signed [AW-1:0]  p_ext;
    logic signed [1:0]     coef;

    // Operand formation; vector mode replicates B column 0 into column 1
    always_comb begin
        for (int j = 0; j < 4; j++) begin
            ae[j] = {a_q[j*DW+DW-1], a_q[j*DW +: DW]};
            be[j] = {b_q[j*DW+DW-1], b_q[j*DW +: DW]};
        end
        if (mode_q == MODE_VEC) begin
            be[E01] = be[E00];
            be[E11] = be[E10];
        end
        case (idx_q)
            3'd0:    begin t_op = ae[E00] + ae[E11]; s_op = be[E00] + be[E11]; end
            3'd1:    begin t_op = ae[E10] + ae[E11]; s_op = be[E00];           end
            3'd2:    begin t_op = ae[E00];           s_op = be[E01] - be[E11]; end
            3'd3:    begin t_op = ae[E11];           s_op = be[E10] - be[E00]; end
            3'd4:    begin t_op = ae[E00] + ae[E01]; s_op = be[E11];           end
            3'd5:    begin t_op = ae[E10] - ae[E00]; s_op = be[E00] + be[E01]; end
            default: begin t_op = ae[E01] - ae[E11]; s_op = be[E10] + be[E11]; end
        endcase
    end

    smm_mul_pipe #(.DW(DW), .LAT(MULT_LAT)) u_mul (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (issue),
        .in_tag    (idx_q),
        .a         (t_op),
        .b         (s_op),
        .out_valid (mul_valid),
        .out_tag   (mul_tag),
        .p         (mul_p),
        .busy      (mul_busy)
    );

    assign p_ext = {{(AW-PW){mul_p[PW-1]}}, mul_p};

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        sat_d   = sat_q;
        issue   = 1'b0;
        coef    = CZ;
        for (int j = 0; j < 4; j++) begin
            coef = (mode_q == MODE_VEC) ? COEF_VEC[mul_tag][j] : COEF_FULL[mul_tag][j];
            if (mul_valid)
                acc_d[j] = (coef == CP) ? acc_q[j] + p_ext :
                           (coef == CN) ? acc_q[j] - p_ext : acc_q[j];
        end
        case (state_q)
            IDLE: if (in_valid && in_ready) begin
                state_d = ISSUE;
                mode_d  = mode_e'(mode);
                a_d     = A;
                b_d     = B;
                idx_d   = mode ? VEC_FIRST : FULL_FIRST;
                for (int j = 0; j < 4; j++) acc_d[j] = '0;
            end
            ISSUE: begin
                issue = 1'b1;
                idx_d = idx_q + 3'd1;
                if (idx_q == ((mode_q == MODE_VEC) ? VEC_LAST : FULL_LAST)) state_d = DRAIN;
            end
            DRAIN: if (!mul_busy) begin
                state_d = DONE;
                sat_d   = 1'b0;
                for (int j = 0; j < 4; j++) begin
`ifdef STRASSEN_SAT_EN
                    c_d[j*DW +: DW] = (acc_q[j] > SMAX) ? SMAX[DW-1:0] :
                                      (acc_q[j] < SMIN) ? SMIN[DW-1:0] : acc_q[j][DW-1:0];
                    sat_d = sat_d | (acc_q[j] > SMAX) | (acc_q[j] < SMIN);
`else
                    c_d[j*DW +: DW] = acc_q[j][DW-1:0];
`endif
                end
            end
            default: if (out_ready) state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= MODE_FULL;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            idx_q   <= '0;
            sat_q   <= 1'b0;
            for (int j = 0; j < 4; j++) acc_q[j] <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            idx_q   <= idx_d;
            sat_q   <= sat_d;
            acc_q   <= acc_d;
        end
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign C         = c_q;
    assign sat       = sat_q;

endmodule

// File: tb/tb_strassen_seq_mm.sv
// tb_strassen_seq_mm: scoreboard bench for strassen_seq_mm with DATAWIDTH=8, MULT_LAT=2.
module tb_strassen_seq_mm;

    localparam int DW  = 8;
    localparam int LAT = 2;

    typedef struct {
        logic [4*DW-1:0] c;
        logic            s;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic            mode;
    logic [4*DW-1:0] A, B, C;
    logic            out_valid;
    logic            out_ready;
    logic            sat;
    logic            busy;

    int   checks = 0;
    int   errors = 0;
    exp_t sb [$];

    strassen_seq_mm #(.DATAWIDTH(DW), .MULT_LAT(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .C         (C),
        .sat       (sat),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [4*DW-1:0] pk(input int x00, input int x01, input int x10, input int x11);
        return {x11[7:0], x10[7:0], x01[7:0], x00[7:0]};
    endfunction

    // Plain matrix product, narrowed by wrap or clamp depending on the build
    function automatic exp_t model(input logic [4*DW-1:0] a, input logic [4*DW-1:0] b, input bit m);
        int   ae [4];
        int   be [4];
        int   r  [4];
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            ae[i] = int'($signed(a[i*DW +: DW]));
            be[i] = int'($signed(b[i*DW +: DW]));
        end
        if (m) begin
            be[1] = be[0];
            be[3] = be[2];
        end
        r[0] = ae[0]*be[0] + ae[1]*be[2];
        r[1] = ae[0]*be[1] + ae[1]*be[3];
        r[2] = ae[2]*be[0] + ae[3]*be[2];
        r[3] = ae[2]*be[1] + ae[3]*be[3];
        if (m) begin
            r[1] = 0;
            r[3] = 0;
        end
        e.s = 1'b0;
        for (int i = 0; i < 4; i++) begin
`ifdef STRASSEN_SAT_EN
            if (r[i] > 127) begin r[i] = 127; e.s = 1'b1; end
            else if (r[i] < -128) begin r[i] = -128; e.s = 1'b1; end
`endif
            e.c[i*DW +: DW] = r[i][7:0];
        end
        return e;
    endfunction

    task automatic accept(input logic [4*DW-1:0] a, input logic [4*DW-1:0] b, input bit m);
        @(negedge clk);
        A = a; B = b; mode = m; in_valid = 1'b1;
        @(posedge clk);
        sb.push_back(model(a, b, m));
        #1;
        in_valid = 1'b0;
        A = $urandom; B = $urandom; mode = $urandom_range(0, 1);
    endtask

    task automatic wait_out(output int lat);
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic release_out;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_during got %b exp 0", in_ready); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (C !== '0) begin errors++; $display("FAIL reset_C got %h exp 0", C); end
        checks++; if (sat !== 1'b0) begin errors++; $display("FAIL reset_sat got %b exp 0", sat); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_op(input string name, input logic [4*DW-1:0] a, input logic [4*DW-1:0] b, input bit m);
        int   lat;
        int   exp_lat;
        exp_t e;
        exp_lat = m ? 5 + LAT : 8 + LAT;
        accept(a, b, m);
        wait_out(lat);
        e = sb.pop_front();
        checks++; if (lat != exp_lat) begin errors++; $display("FAIL %s latency got %0d exp %0d", name, lat, exp_lat); end
        checks++; if (C !== e.c) begin errors++; $display("FAIL %s C got %h exp %h", name, C, e.c); end
        checks++; if (sat !== e.s) begin errors++; $display("FAIL %s sat got %b exp %b", name, sat, e.s); end
        release_out();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s out_valid_drop got %b exp 0", name, out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL %s in_ready_after got %b exp 1", name, in_ready); end
    endtask

    task automatic test_back_to_back;
        int              lat;
        exp_t            e;
        logic [4*DW-1:0] held;
        logic [4*DW-1:0] na, nb;
        accept(pk(1, 2, 3, 4), pk(5, 6, 7, 8), 1'b0);
        wait_out(lat);
        e = sb.pop_front();
        checks++; if (C !== e.c) begin errors++; $display("FAIL bp_first C got %h exp %h", C, e.c); end
        na = pk(-7, 3, 12, -5);
        nb = pk(9, -2, 4, 11);
        @(negedge clk);
        A = na; B = nb; mode = 1'b0; in_valid = 1'b1;
        held = C;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++; if (C !== held) begin errors++; $display("FAIL bp_hold_C got %h exp %h", C, held); end
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid got %b exp 1", out_valid); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b exp 0", in_ready); end
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_release got %b exp 1", in_ready); end
        @(posedge clk);
        sb.push_back(model(na, nb, 1'b0));
        #1;
        in_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_accept_busy got %b exp 1", busy); end
        wait_out(lat);
        e = sb.pop_front();
        checks++; if (lat != 8 + LAT) begin errors++; $display("FAIL bp_second latency got %0d exp %0d", lat, 8 + LAT); end
        checks++; if (C !== e.c) begin errors++; $display("FAIL bp_second C got %h exp %h", C, e.c); end
        release_out();
    endtask

    task automatic test_reset_mid;
        accept(pk(-50, 77, 33, -90), pk(100, -100, 64, 27), 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        void'(sb.pop_front());
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_out_valid got %b exp 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got %b exp 0", busy); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        test_op("after_rst", pk(1, 2, 3, 4), pk(5, 6, 7, 8), 1'b0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; mode = 1'b0; A = '0; B = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_op("full_basic", pk(1, 2, 3, 4), pk(5, 6, 7, 8), 1'b0);
        test_op("vec_basic", pk(1, 2, 3, 4), pk(5, 99, 7, -3), 1'b1);
        test_op("sat_pos", pk(100, 100, 0, 0), pk(100, 0, 100, 0), 1'b0);
        test_op("sat_neg", pk(-128, -128, 0, 0), pk(127, 0, 127, 0), 1'b0);
        test_op("extremes", pk(-128, 127, -128, 127), pk(-128, -128, 127, 127), 1'b0);
        for (int i = 0; i < 8; i++)
            test_op("random", $urandom, $urandom, i[0]);
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
